act_fetch_unit: RTL and testbench

ACT_FETCH_UNIT -- requirements
Module: act_fetch_unit

---
 rtl/act_fetch_unit.sv | 180 ++++++++++++++++++
 tb/tb_act_fetch_unit.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/act_fetch_unit.sv
// rtl/act_fetch_unit.sv - activation row store streamed as serial nonzero beats or whole-row beats
// Build option ACT_FETCH_ZERO_GATE_EN: parallel beats zero every lane whose flag bit is clear.
module act_fetch_unit #(
  parameter int LANES      = 16,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64,
  localparam int AW        = $clog2(DEPTH),
  localparam int IW        = $clog2(LANES)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [AW-1:0]               wr_addr,
  input  logic [LANES-1:0]            wr_flag,
  input  logic [LANES*DATA_WIDTH-1:0] wr_data,
  input  logic                        mode,
  input  logic                        start,
  input  logic [AW-1:0]               base_addr,
  input  logic [AW:0]                 num_rows,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [LANES*DATA_WIDTH-1:0] out_data,
  output logic [IW-1:0]               out_index,
  output logic [LANES-1:0]            out_flag,
  output logic                        out_last_in_row,
  output logic [IW:0]                 row_nnz,
  output logic                        busy,
  output logic                        done
);

  localparam int DW_ROW = LANES * DATA_WIDTH;
  localparam int RW     = LANES + DW_ROW;

  typedef enum logic [2:0] {IDLE, READ, LOAD, EMIT, DONE} state_t;

  state_t state, next_state;

  logic [RW-1:0]      mem [DEPTH];
  logic [RW-1:0]      rd_word;
  logic [LANES-1:0]   rd_flag;
  logic [DW_ROW-1:0]  rd_data;
  logic [AW-1:0]      rd_addr;

  logic               mode_q;
  logic [AW-1:0]      base_q;
  logic [AW:0]        rows_q;
  logic [AW:0]        row_q;
  logic [AW:0]        row_next;
  logic [LANES-1:0]   flag_q;
  logic [LANES-1:0]   remain_q;
  logic [DW_ROW-1:0]  data_q;
  logic [DW_ROW-1:0]  par_data;
  logic [IW:0]        nnz_q;
  logic [IW-1:0]      low_idx;
  logic               last_serial;
  logic               beat_last;
  logic               row_is_last;
  logic               skip_row;

  function automatic logic [IW:0] popcount(input logic [LANES-1:0] f);
    popcount = '0;
    for (int i = 0; i < LANES; i++) popcount = popcount + (IW+1)'(f[i]);
  endfunction

  assign rd_flag     = rd_word[RW-1 -: LANES];
  assign rd_data     = rd_word[DW_ROW-1:0];
  assign rd_addr     = base_q + row_q[AW-1:0];
  assign row_next    = row_q + (AW+1)'(1);
  assign row_is_last = (row_next == rows_q);
  assign skip_row    = !mode_q && (rd_flag == '0);
  assign last_serial = ((remain_q & (remain_q - LANES'(1))) == '0);
  assign beat_last   = mode_q ? 1'b1 : last_serial;

  always_comb begin
    low_idx = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (remain_q[i]) low_idx = IW'(i);
    end
  end

`ifdef ACT_FETCH_ZERO_GATE_EN
  always_comb begin
    par_data = '0;
    for (int i = 0; i < LANES; i++) begin
      if (flag_q[i]) par_data[i*DATA_WIDTH +: DATA_WIDTH] = data_q[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end
`else
  assign par_data = data_q;
`endif

  // Array is deliberately unreset; a same-edge write leaves the read returning old contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= {wr_flag, wr_data};
    if (state == READ) rd_word <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = (num_rows == '0) ? DONE : READ;
      READ: next_state = LOAD;
      LOAD: begin
        if (skip_row) next_state = row_is_last ? DONE : READ;
        else          next_state = EMIT;
      end
      EMIT: if (out_ready && beat_last) next_state = row_is_last ? DONE : READ;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q   <= 1'b0;
      base_q   <= '0;
      rows_q   <= '0;
      row_q    <= '0;
      flag_q   <= '0;
      remain_q <= '0;
      data_q   <= '0;
      nnz_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && num_rows != '0) begin
            mode_q <= mode;
            base_q <= base_addr;
            rows_q <= num_rows;
            row_q  <= '0;
          end
        end
        LOAD: begin
          flag_q   <= rd_flag;
          remain_q <= rd_flag;
          data_q   <= rd_data;
          nnz_q    <= popcount(rd_flag);
          if (skip_row) row_q <= row_next;
        end
        EMIT: begin
          if (out_ready) begin
            // Clearing the lowest set bit retires exactly the lane just emitted.
            if (!mode_q) remain_q <= remain_q & (remain_q - LANES'(1));
            if (beat_last) row_q <= row_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_flag = flag_q;
  assign row_nnz  = nnz_q;

  always_comb begin
    out_valid       = 1'b0;
    out_data        = '0;
    out_index       = '0;
    out_last_in_row = 1'b0;
    busy            = (state != IDLE);
    done            = (state == DONE);
    if (state == EMIT) begin
      out_valid = 1'b1;
      if (mode_q) begin
        out_data        = par_data;
        out_last_in_row = 1'b1;
      end else begin
        out_data[DATA_WIDTH-1:0] = data_q[low_idx*DATA_WIDTH +: DATA_WIDTH];
        out_index                = low_idx;
        out_last_in_row          = last_serial;
      end
    end
  end

endmodule

// File: tb/tb_act_fetch_unit.sv
// tb/tb_act_fetch_unit.sv - scoreboard bench for act_fetch_unit
module tb_act_fetch_unit;
  localparam int LANES = 16, DW = 8, DEPTH = 64, AW = 6, IW = 4;

  logic clk = 1'b0, reset = 1'b0;
  logic wr_en = 1'b0, mode = 1'b0, start = 1'b0, out_ready = 1'b1;
  logic [AW-1:0] wr_addr = '0, base_addr = '0;
  logic [AW:0] num_rows = '0;
  logic [LANES-1:0] wr_flag = '0;
  logic [LANES*DW-1:0] wr_data = '0;
  logic out_valid, out_last_in_row, busy, done;
  logic [LANES*DW-1:0] out_data;
  logic [IW-1:0] out_index;
  logic [LANES-1:0] out_flag;
  logic [IW:0] row_nnz;

  act_fetch_unit #(.LANES(LANES), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_flag(wr_flag),
    .wr_data(wr_data), .mode(mode), .start(start), .base_addr(base_addr),
    .num_rows(num_rows), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .out_index(out_index), .out_flag(out_flag),
    .out_last_in_row(out_last_in_row), .row_nnz(row_nnz), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0]       idx;
    logic [LANES*DW-1:0] data;
    logic                last;
    logic [IW:0]         nnz;
  } beat_t;

  beat_t exp_q[$];
  logic [LANES-1:0]    m_flag [DEPTH];
  logic [LANES*DW-1:0] m_data [DEPTH];
  int vectors = 0, miscompares = 0, beats_seen = 0;

  logic stalled = 1'b0;
  logic [LANES*DW-1:0] hold_data;
  logic [IW-1:0] hold_idx;
  logic [LANES-1:0] hold_flag;
  bit log_en = 0;
  logic [IW:0] nnz_prev;
  logic [IW:0] nnz_log[$];

  // Output monitor: scoreboard pop on accepted beats, stability under backpressure.
  always @(negedge clk) begin
    beat_t e;
    if (!reset) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        vectors++;
        if (out_valid !== 1'b1 || out_data !== hold_data || out_index !== hold_idx || out_flag !== hold_flag) begin
          miscompares++;
          $display("FAIL hold: valid=%b idx=%0d data=%h, required valid=1 idx=%0d data=%h",
                   out_valid, out_index, out_data, hold_idx, hold_data);
        end
      end
      if (out_valid && out_ready) begin
        beats_seen++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL extra_beat: idx=%0d data=%h, required no beat", out_index, out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_index !== e.idx || out_data !== e.data || out_last_in_row !== e.last || row_nnz !== e.nnz) begin
            miscompares++;
            $display("FAIL beat: idx=%0d data=%h last=%b nnz=%0d, required idx=%0d data=%h last=%b nnz=%0d",
                     out_index, out_data, out_last_in_row, row_nnz, e.idx, e.data, e.last, e.nnz);
          end
        end
      end
      stalled   = out_valid && !out_ready;
      hold_data = out_data;
      hold_idx  = out_index;
      hold_flag = out_flag;
      if (log_en && row_nnz !== nnz_prev) begin
        nnz_log.push_back(row_nnz);
        nnz_prev = row_nnz;
      end
    end
  end

  function automatic logic [LANES*DW-1:0] rand_row();
    logic [LANES*DW-1:0] d;
    for (int i = 0; i < LANES; i++) d[i*DW +: DW] = 8'($urandom_range(1, 255));
    return d;
  endfunction

  task automatic write_row(input int a, input logic [LANES-1:0] f, input logic [LANES*DW-1:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = AW'(a); wr_flag = f; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    m_flag[a] = f;
    m_data[a] = d;
  endtask

  task automatic push_job(input bit md, input int base, input int rows, output int exp_cyc);
    int a, nnz, cnt;
    logic [LANES-1:0] f;
    beat_t b;
    exp_cyc = 1;
    for (int r = 0; r < rows; r++) begin
      a = (base + r) % DEPTH;
      f = m_flag[a];
      nnz = 0;
      for (int i = 0; i < LANES; i++) nnz += int'(f[i]);
      if (md) begin
        b.idx = '0; b.data = m_data[a]; b.last = 1'b1; b.nnz = (IW+1)'(nnz);
`ifdef ACT_FETCH_ZERO_GATE_EN
        for (int i = 0; i < LANES; i++) if (!f[i]) b.data[i*DW +: DW] = '0;
`endif
        exp_q.push_back(b);
        exp_cyc += 3;
      end else begin
        exp_cyc += 2;
        cnt = 0;
        for (int i = 0; i < LANES; i++) begin
          if (f[i]) begin
            cnt++;
            b.idx = IW'(i); b.data = '0; b.data[DW-1:0] = m_data[a][i*DW +: DW];
            b.last = (cnt == nnz); b.nnz = (IW+1)'(nnz);
            exp_q.push_back(b);
            exp_cyc++;
          end
        end
      end
    end
  endtask

  task automatic run_job(input bit md, input int base, input int rows, input int stall,
                         output int cycles, output bit got_done, output bit after_ok);
    int st;
    bit seen;
    st = 0; seen = 0; got_done = 0; cycles = 0;
    @(posedge clk); #1;
    mode = md; base_addr = AW'(base); num_rows = (AW+1)'(rows); start = 1'b1;
    for (int c = 1; c <= 2000; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      mode = ~md;
      if (seen && st < stall) begin out_ready = 1'b0; st++; end
      else out_ready = 1'b1;
      @(negedge clk);
      if (out_valid) seen = 1;
      if (done) begin got_done = 1; cycles = c; break; end
    end
    @(negedge clk);
    after_ok = (done === 1'b0 && busy === 1'b0);
  endtask

  task automatic check_job(input string name, input int cycles, input int exp_cyc, input bit got_done,
                           input bit after_ok, input int beats, input int exp_beats);
    vectors++;
    if (!got_done) begin miscompares++; $display("FAIL %s_done: no done pulse, required done", name); end
    vectors++;
    if (cycles != exp_cyc) begin miscompares++; $display("FAIL %s_cycles: %0d, required %0d", name, cycles, exp_cyc); end
    vectors++;
    if (!after_ok) begin miscompares++; $display("FAIL %s_after: done/busy still high, required 0/0", name); end
    vectors++;
    if (beats != exp_beats || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_beats: %0d beats, %0d pending, required %0d beats 0 pending", name, beats, exp_q.size(), exp_beats);
    end
    exp_q.delete();
  endtask

  task automatic test_reset;
    #1;
    vectors++;
    if ({out_valid, out_last_in_row, busy, done} !== 4'b0 || out_data !== '0 || out_index !== '0 ||
        out_flag !== '0 || row_nnz !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: valid=%b busy=%b done=%b data=%h flag=%h nnz=%0d, required all 0",
               out_valid, busy, done, out_data, out_flag, row_nnz);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_idle: busy=%b, required 0", busy); end
  endtask

  task automatic test_serial_basic;
    logic [LANES*DW-1:0] d;
    int ec, cy, b0; bit gd, ao;
    for (int i = 0; i < LANES; i++) d[i*DW +: DW] = 8'(i + 1);
    write_row(3, 16'h8011, d);
    push_job(0, 3, 1, ec);
    b0 = beats_seen;
    run_job(0, 3, 1, 0, cy, gd, ao);
    check_job("serial_basic", cy, ec, gd, ao, beats_seen - b0, 3);
  endtask

  task automatic test_skip_rows;
    int ec, cy, b0; bit gd, ao;
    write_row(0, 16'h0001, rand_row());
    write_row(1, 16'h0000, rand_row());
    write_row(2, 16'h0002, rand_row());
    push_job(0, 0, 3, ec);
    b0 = beats_seen;
    nnz_prev = row_nnz;
    nnz_log.delete();
    log_en = 1;
    run_job(0, 0, 3, 0, cy, gd, ao);
    log_en = 0;
    check_job("skip_rows", cy, ec, gd, ao, beats_seen - b0, 2);
    vectors++;
    if (nnz_log.size() != 3 || nnz_log[0] !== 5'd1 || nnz_log[1] !== 5'd0 || nnz_log[2] !== 5'd1) begin
      miscompares++;
      $display("FAIL skip_nnz_trace: %0d changes, required 3 changes 1,0,1", nnz_log.size());
    end
  endtask

  task automatic test_parallel;
    int ec, cy, b0; bit gd, ao;
    push_job(1, 0, 3, ec);
    b0 = beats_seen;
    run_job(1, 0, 3, 0, cy, gd, ao);
    check_job("parallel", cy, ec, gd, ao, beats_seen - b0, 3);
  endtask

  task automatic test_backpressure;
    int ec, cy, b0; bit gd, ao;
    push_job(0, 3, 1, ec);
    b0 = beats_seen;
    run_job(0, 3, 1, 5, cy, gd, ao);
    check_job("backpressure", cy, ec + 5, gd, ao, beats_seen - b0, 3);
  endtask

  task automatic test_wrap;
    int ec, cy, b0; bit gd, ao;
    write_row(63, 16'h0300, rand_row());
    write_row(0, 16'h4002, rand_row());
    push_job(0, 63, 2, ec);
    b0 = beats_seen;
    run_job(0, 63, 2, 0, cy, gd, ao);
    check_job("wrap_serial", cy, ec, gd, ao, beats_seen - b0, 4);
    push_job(1, 63, 2, ec);
    b0 = beats_seen;
    run_job(1, 63, 2, 0, cy, gd, ao);
    check_job("wrap_parallel", cy, ec, gd, ao, beats_seen - b0, 2);
  endtask

  task automatic test_zero_rows;
    int ec, cy, b0; bit gd, ao;
    push_job(0, 10, 0, ec);
    b0 = beats_seen;
    run_job(0, 10, 0, 0, cy, gd, ao);
    check_job("zero_rows", cy, ec, gd, ao, beats_seen - b0, 0);
  endtask

  task automatic test_same_addr;
    logic [LANES*DW-1:0] nd;
    int ec; bit gd;
    write_row(5, 16'h00f0, rand_row());
    nd = rand_row();
    push_job(1, 5, 1, ec);
    @(posedge clk); #1;
    mode = 1'b1; base_addr = 6'd5; num_rows = 7'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b1; wr_addr = 6'd5; wr_flag = 16'hffff; wr_data = nd;
    @(posedge clk); #1;
    wr_en = 1'b0;
    m_flag[5] = 16'hffff;
    m_data[5] = nd;
    gd = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) begin gd = 1; break; end
    end
    vectors++;
    if (!gd || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL same_addr: done=%b pending=%0d, required done=1 pending=0", gd, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid;
    int ec, cy, b0; bit gd, ao, seen, dn;
    write_row(7, 16'hffff, rand_row());
    @(posedge clk); #1;
    out_ready = 1'b0; mode = 1'b0; base_addr = 6'd7; num_rows = 7'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1; break; end
    end
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL reset_mid_emit: out_valid=0, required 1"); end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({out_valid, out_last_in_row, busy, done} !== 4'b0 || out_data !== '0 || out_index !== '0 ||
        out_flag !== '0 || row_nnz !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: valid=%b busy=%b done=%b data=%h flag=%h nnz=%0d, required all 0",
               out_valid, busy, done, out_data, out_flag, row_nnz);
    end
    dn = 0;
    repeat (2) begin @(negedge clk); if (done) dn = 1; end
    @(posedge clk); #1;
    reset = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    if (done) dn = 1;
    vectors++;
    if (dn || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_abort: done_seen=%b busy=%b, required 0/0", dn, busy);
    end
    push_job(0, 3, 1, ec);
    b0 = beats_seen;
    run_job(0, 3, 1, 0, cy, gd, ao);
    check_job("after_reset", cy, ec, gd, ao, beats_seen - b0, 3);
  endtask

  initial begin
    test_reset();
    test_serial_basic();
    test_skip_rows();
    test_parallel();
    test_backpressure();
    test_wrap();
    test_zero_rows();
    test_same_addr();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
